inst_axi_rd_bridge: RTL and testbench
=====================================

# inst_axi_rd_bridge

The instruction-side bridge sits directly downstream of the I-cache. It takes the cache's SRAM-like miss-refill requests (`cache_inst_*`) and turns each one into a single-beat AXI4 read on the AR/R channels. It returns the data through the SRAM-like data handshake. Only one transaction is outstanding at a time. The block is read-only by design.

## Interface
Parameters:
- `ID_WIDTH`, 4, width of `arid`/`rid`.
- `ARID_VAL`, 0, constant driven on `arid`.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `inst_req`  in  1  request from the I-cache; held until `inst_addr_ok`.
- `inst_wr`  in  1  write flag; writes are unsupported (see Operation).
- `inst_size`  in  2  log2 of the byte count.
- `inst_addr`  in  32  byte address.
- `inst_wdata`  in  32  ignored.
- `inst_rdata`  out  32  read data; valid while `inst_data_ok`=1.
- `inst_addr_ok`  out  1  request accepted this cycle.
- `inst_data_ok`  out  1  one-cycle completion pulse.
- `arid`  out  `ID_WIDTH`  = `ARID_VAL`.
- `araddr`  out  32  latched address.
- `arlen`  out  8  = 0.
- `arsize`  out  3  = {1'b0, latched size}.
- `arburst`  out  2  = 2'b01 (INCR).
- `arlock`  out  2  = 0.
- `arcache`  out  4  = 0.
- `arprot`  out  3  = 0.
- `arvalid`  in/out: out  1  AR valid.
- `arready`  in  1  AR ready.
- `rid`  in  `ID_WIDTH`  ignored (single outstanding).
- `rdata`  in  32  read data.
- `rresp`  in  2  response.
- `rlast`  in  1  last beat.
- `rvalid`  in  1  R valid.
- `rready`  out  1  R ready.
- `bus_err`  out  1  sticky error flag (see Configuration).

## Operation
FSM states: IDLE, AR, R, DONE, WDONE.

- **IDLE**
  - `inst_addr_ok` = `inst_req`, combinationally.
  - On `inst_req` & ~`inst_wr`: latch `inst_addr` and `inst_size`, then go to AR.
  - On `inst_req` & `inst_wr`: go to WDONE. No AXI traffic is issued.
- **AR**
  - `arvalid`=1; `araddr`/`arsize` come from the latches and stay stable until the handshake.
  - On `arready`: go to R.
- **R**
  - `rready`=1.
  - On `rvalid` & `rlast`: register `rdata` into the data latch and go to DONE.
  - A beat with `rvalid` & ~`rlast` is consumed and discarded; the FSM stays in R.
- **DONE**
  - `inst_data_ok`=1 and `inst_rdata` = the data latch.
  - Go to IDLE. No new request is accepted in this cycle.
- **WDONE**
  - `inst_data_ok`=1 and `inst_rdata`=0.
  - Go to IDLE.
- `inst_addr_ok` is 0 in every state except IDLE.
- `rready` is 0 outside R, so an R beat arriving in any other state is not consumed.
- Reset mid-transaction: all outputs drop to their reset values immediately, and the FSM returns to IDLE. An in-flight AXI read is abandoned, and its late R beat is not tracked.

## Timing
- Reset values:
  - FSM = IDLE.
  - `arvalid`=0, `rready`=0, `inst_data_ok`=0, `inst_rdata`=0, data latch = 0, address/size latches = 0, `bus_err`=0.
  - `inst_addr_ok`=0 while `rst`=0.
- Best-case read with request accepted in cycle T0:
  - `arvalid` rises at T1; `arready` arrives at T1.
  - `rvalid`+`rlast` arrive at T2.
  - `inst_data_ok` pulses at T3.
- Write: `inst_addr_ok` at T0, `inst_data_ok` at T1.
- Back-to-back requests: the next `inst_addr_ok` comes no earlier than the cycle after `inst_data_ok`.
- `arvalid` never deasserts before `arready` is seen.

## Configuration
- `INST_BRIDGE_RRESP_CHECK_EN` defined:
  - `bus_err` is set on the final R beat when `rresp` != 2'b00.
  - It is sticky and cleared only by reset.
  - Data is still returned normally.
- Undefined: `bus_err` is tied to 0 and `rresp` is unused.

## Test plan
- **Reset:** `rst`=0 while `inst_req`=1 → `inst_addr_ok`=0, `arvalid`=0, `rready`=0; after release the FSM is in IDLE.
- **Basic read:** read of 0xBFC00000 with size 2, `arready` immediate, R returns 0x3C08BFC0 one cycle later with `rlast`=1 → `araddr`=0xBFC00000, `arsize`=3'b010, `arlen`=0, `arburst`=01; `inst_data_ok` pulses exactly once with `inst_rdata`=0x3C08BFC0.
- **Slave stalls:** `arready` held low for 5 cycles, then `rvalid` delayed 7 cycles → `arvalid` and `araddr` stay stable for all 5 cycles; exactly one AR handshake and one `inst_data_ok`.
- **Write request:** `inst_wr`=1 → `inst_addr_ok` at T0, `inst_data_ok` at T1 with `inst_rdata`=0; `arvalid` never rises.
- **Error response with macro defined:** `rresp`=2'b10 → `bus_err`=1 and stays 1 through subsequent OKAY reads; without the macro, `bus_err` stays 0.
- **Reset mid-read:** `rst` asserted while in R → `rready` drops in the same cycle; after release, a new read of 0x00001000 completes normally.

Source files
------------

// File: rtl/inst_axi_rd_bridge.sv
// inst_axi_rd_bridge
//   Instruction-side bridge between the I-cache SRAM-like refill port and an
//   AXI4 read channel. Each accepted request becomes one single-beat AXI read.
//   Only one transaction is in flight at a time. Write requests are not
//   supported: they are acknowledged with zero data and generate no AXI traffic.
//
// Optional feature macro: INST_BRIDGE_RRESP_CHECK_EN
//   When defined, a non-OKAY rresp on the final R beat sets the sticky bus_err
//   flag, which only reset clears. When undefined, bus_err is tied low.
//
// Ports
//   clk, rst                 clock (rising edge), async active-low reset
//   inst_req/wr/size/addr/wdata
//                            SRAM-like request from the I-cache
//   inst_rdata/addr_ok/data_ok
//                            SRAM-like response to the I-cache
//   ar*                      AXI read address channel (arid = ARID_VAL)
//   rid/rdata/rresp/rlast/rvalid/rready
//                            AXI read data channel
//   bus_err                  sticky read-error flag
module inst_axi_rd_bridge #(
  parameter int                    ID_WIDTH = 4,
  parameter logic [ID_WIDTH-1:0]   ARID_VAL = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_req,
  input  logic                inst_wr,
  input  logic [1:0]          inst_size,
  input  logic [31:0]         inst_addr,
  input  logic [31:0]         inst_wdata,
  output logic [31:0]         inst_rdata,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [ID_WIDTH-1:0] arid,
  output logic [31:0]         araddr,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic [1:0]          arlock,
  output logic [3:0]          arcache,
  output logic [2:0]          arprot,
  output logic                arvalid,
  input  logic                arready,
  input  logic [ID_WIDTH-1:0] rid,
  input  logic [31:0]         rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready,
  output logic                bus_err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    AR    = 3'd1,
    R     = 3'd2,
    DONE  = 3'd3,
    WDONE = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q,  addr_d;
  logic [1:0]  size_q,  size_d;
  logic [31:0] data_q,  data_d;

  // Final beat of the read: the only beat whose data and response matter.
  logic last_beat;
  assign last_beat = (state_q == R) && rvalid && rlast;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    size_d       = size_q;
    data_d       = data_q;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata   = '0;
    arvalid      = 1'b0;
    rready       = 1'b0;
    case (state_q)
      IDLE: begin
        // Gated by rst so nothing is accepted while reset is held.
        inst_addr_ok = inst_req & rst;
        if (inst_req) begin
          if (inst_wr) begin
            state_d = WDONE;
          end else begin
            addr_d  = inst_addr;
            size_d  = inst_size;
            state_d = AR;
          end
        end
      end
      AR: begin
        arvalid = 1'b1;
        if (arready) state_d = R;
      end
      R: begin
        rready = 1'b1;
        // Non-last beats are accepted and dropped; only the last one is kept.
        if (last_beat) begin
          data_d  = rdata;
          state_d = DONE;
        end
      end
      DONE: begin
        inst_data_ok = 1'b1;
        inst_rdata   = data_q;
        state_d      = IDLE;
      end
      WDONE: begin
        inst_data_ok = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign arid    = ARID_VAL;
  assign araddr  = addr_q;
  assign arlen   = 8'd0;
  assign arsize  = {1'b0, size_q};
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;

`ifdef INST_BRIDGE_RRESP_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (last_beat && (rresp != 2'b00)) begin
      err_q <= 1'b1;
    end
  end

  assign bus_err = err_q;

  logic unused_ok;
  assign unused_ok = ^{rid, inst_wdata};
`else
  assign bus_err = 1'b0;

  logic unused_ok;
  assign unused_ok = ^{rid, inst_wdata, rresp};
`endif

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
module tb_inst_axi_rd_bridge;

  localparam int IDW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            inst_req, inst_wr;
  logic [1:0]      inst_size;
  logic [31:0]     inst_addr, inst_wdata;
  logic [31:0]     inst_rdata;
  logic            inst_addr_ok, inst_data_ok;
  logic [IDW-1:0]  arid;
  logic [31:0]     araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst, arlock;
  logic [3:0]      arcache;
  logic [2:0]      arprot;
  logic            arvalid, arready;
  logic [IDW-1:0]  rid;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast, rvalid, rready;
  logic            bus_err;

  int checks = 0;
  int errors = 0;
  logic err_model = 1'b0;

`ifdef INST_BRIDGE_RRESP_CHECK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  inst_axi_rd_bridge #(.ID_WIDTH(IDW), .ARID_VAL(4'd0)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        wr;
    int          ar_dly;
    int          r_dly;
    logic        nl_beat;
    logic [31:0] data;
    logic [1:0]  resp;
    logic [31:0] exp_rdata;
    logic [2:0]  exp_arsize;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    inst_req  = 1'b1;
    inst_wr   = v.wr;
    inst_addr = v.addr;
    inst_size = v.size;
    #1;
    chk("addr_ok_T0", {31'd0, inst_addr_ok}, 32'd1);
    chk("arvalid_T0", {31'd0, arvalid}, 32'd0);
    step();
    inst_req  = 1'b0;
    inst_wr   = 1'b0;
    inst_addr = 32'hFFFF_FFFF;
    inst_size = 2'b11;
    if (v.wr) begin
      chk("wr_data_ok", {31'd0, inst_data_ok}, 32'd1);
      chk("wr_rdata", inst_rdata, v.exp_rdata);
      chk("wr_arvalid", {31'd0, arvalid}, 32'd0);
      step();
      chk("wr_data_ok_clr", {31'd0, inst_data_ok}, 32'd0);
    end else begin
      chk("arvalid", {31'd0, arvalid}, 32'd1);
      chk("araddr", araddr, v.addr);
      chk("arsize", {29'd0, arsize}, {29'd0, v.exp_arsize});
      chk("arlen_burst", {22'd0, arlen, arburst}, {22'd0, 8'd0, 2'b01});
      chk("addr_ok_busy", {31'd0, inst_addr_ok}, 32'd0);
      for (int i = 0; i < v.ar_dly; i++) begin
        arready = 1'b0;
        step();
        chk("stall_arvalid", {31'd0, arvalid}, 32'd1);
        chk("stall_araddr", araddr, v.addr);
      end
      arready = 1'b1;
      step();
      arready = 1'b0;
      chk("rready", {31'd0, rready}, 32'd1);
      chk("arvalid_after_hs", {31'd0, arvalid}, 32'd0);
      for (int i = 0; i < v.r_dly; i++) begin
        step();
        chk("wait_arvalid", {31'd0, arvalid}, 32'd0);
        chk("wait_data_ok", {31'd0, inst_data_ok}, 32'd0);
      end
      if (v.nl_beat) begin
        rvalid = 1'b1; rlast = 1'b0; rdata = 32'h5555_AAAA; rresp = 2'b00;
        step();
        chk("nl_data_ok", {31'd0, inst_data_ok}, 32'd0);
        chk("nl_rready", {31'd0, rready}, 32'd1);
      end
      rvalid = 1'b1; rlast = 1'b1; rdata = v.data; rresp = v.resp;
      step();
      rvalid = 1'b0; rlast = 1'b0; rdata = 32'h0; rresp = 2'b00;
      if (ERR_EN && v.resp != 2'b00) err_model = 1'b1;
      chk("data_ok", {31'd0, inst_data_ok}, 32'd1);
      chk("rdata", inst_rdata, v.exp_rdata);
      chk("rready_done", {31'd0, rready}, 32'd0);
      chk("bus_err", {31'd0, bus_err}, {31'd0, err_model});
      // A request presented during the completion cycle must wait one cycle.
      inst_req  = 1'b1;
      inst_addr = 32'h0;
      #1;
      chk("addr_ok_in_done", {31'd0, inst_addr_ok}, 32'd0);
      inst_req = 1'b0;
      step();
      chk("data_ok_clr", {31'd0, inst_data_ok}, 32'd0);
      chk("bus_err_hold", {31'd0, bus_err}, {31'd0, err_model});
    end
  endtask

  initial begin
    vecs[0] = '{32'hBFC0_0000, 2'd2, 1'b0, 0, 0, 1'b0, 32'h3C08_BFC0, 2'b00, 32'h3C08_BFC0, 3'b010};
    vecs[1] = '{32'h8000_1234, 2'd1, 1'b0, 5, 7, 1'b0, 32'hDEAD_BEEF, 2'b00, 32'hDEAD_BEEF, 3'b001};
    vecs[2] = '{32'h0000_0040, 2'd0, 1'b1, 0, 0, 1'b0, 32'h0,         2'b00, 32'h0,         3'b000};
    vecs[3] = '{32'h1234_5678, 2'd2, 1'b0, 2, 1, 1'b1, 32'hCAFE_F00D, 2'b00, 32'hCAFE_F00D, 3'b010};
    vecs[4] = '{32'hA000_0000, 2'd2, 1'b0, 0, 0, 1'b0, 32'h1111_1111, 2'b10, 32'h1111_1111, 3'b010};
    vecs[5] = '{32'hA000_0004, 2'd2, 1'b0, 1, 0, 1'b0, 32'h2222_2222, 2'b00, 32'h2222_2222, 3'b010};
    vecs[6] = '{32'h0000_0000, 2'd0, 1'b1, 0, 0, 1'b0, 32'h0,         2'b00, 32'h0,         3'b000};

    rst = 1'b0;
    inst_req = 1'b1; inst_wr = 1'b0; inst_size = 2'd2; inst_addr = 32'h1234_0000;
    inst_wdata = 32'hA5A5_A5A5;
    arready = 1'b0; rid = '0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;

    // Reset held with a pending request.
    step();
    step();
    chk("rst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
    chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
    chk("rst_rready", {31'd0, rready}, 32'd0);
    chk("rst_data_ok", {31'd0, inst_data_ok}, 32'd0);
    chk("rst_rdata", inst_rdata, 32'h0);
    chk("rst_araddr", araddr, 32'h0);
    chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
    inst_req = 1'b0;
    rst = 1'b1;
    step();
    chk("idle_arvalid", {31'd0, arvalid}, 32'd0);

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i]);
      step();
    end

    // Reset while waiting for R data.
    inst_req = 1'b1; inst_wr = 1'b0; inst_addr = 32'h0000_2000; inst_size = 2'd2;
    step();
    inst_req = 1'b0;
    arready = 1'b1;
    step();
    arready = 1'b0;
    chk("mid_rready_pre", {31'd0, rready}, 32'd1);
    #1;
    rst = 1'b0;
    err_model = 1'b0;
    #1;
    chk("mid_rready_drop", {31'd0, rready}, 32'd0);
    chk("mid_arvalid", {31'd0, arvalid}, 32'd0);
    chk("mid_bus_err", {31'd0, bus_err}, 32'd0);
    step();
    rst = 1'b1;
    // Stale R beat after reset must not produce a completion.
    rvalid = 1'b1; rlast = 1'b1; rdata = 32'hBAD0_BAD0;
    step();
    rvalid = 1'b0; rlast = 1'b0; rdata = 32'h0;
    chk("stale_data_ok", {31'd0, inst_data_ok}, 32'd0);
    chk("stale_rready", {31'd0, rready}, 32'd0);
    run_vec('{32'h0000_1000, 2'd2, 1'b0, 0, 0, 1'b0, 32'h0123_4567, 2'b00, 32'h0123_4567, 3'b010});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
